// File: rtl/imm_gen_pipe_if.sv
// Purpose: instruction-in / immediate-out stream bundle for imm_gen_pipe.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; the producer holds data until ready.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_illegal;

    // Instruction source / immediate consumer side
    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illegal
    );

    // Decoder side
    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Purpose: RV32 immediate decoder feeding a 2-entry head/skid elastic buffer, plus illegal-op counter.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready is registered and drops only when both entries are full; no combinational path from out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_gen_pipe_if.slave    bus,
    input  logic             ill_clr,
    output logic [CNT_W-1:0] ill_cnt
);
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] TY_R     = 3'd0;
    localparam logic [2:0] TY_I     = 3'd1;
    localparam logic [2:0] TY_S     = 3'd2;
    localparam logic [2:0] TY_B     = 3'd3;
    localparam logic [2:0] TY_U     = 3'd4;
    localparam logic [2:0] TY_J     = 3'd5;
    localparam logic [2:0] TY_SHAMT = 3'd6;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [31:0]     inst;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            dec_ill;
    logic [5:0]      shamt;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            rdy_q;
    logic            push;
    logic            pop;

    logic [XLEN-1:0] head_imm;
    logic [2:0]      head_type;
    logic            head_ill;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_type;
    logic            skid_ill;

    assign inst = bus.in_inst;
    assign push = bus.in_valid && rdy_q;
    assign pop  = (state != ST_EMPTY) && bus.out_ready;

    assign bus.in_ready    = rdy_q;
    assign bus.out_valid   = (state != ST_EMPTY);
    assign bus.out_imm     = head_imm;
    assign bus.out_type    = head_type;
    assign bus.out_illegal = head_ill;

    // Decode the incoming word ahead of the buffer; unknown encodings become illegal with a zero immediate.
    always_comb begin
        dec_imm  = '0;
        dec_type = TY_R;
        dec_ill  = 1'b0;
        shamt    = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
        if (inst[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (inst[6:2])
                5'b00100: begin
                    if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
                        dec_type = TY_SHAMT;
                        dec_imm  = XLEN'(shamt);
                    end else begin
                        dec_type = TY_I;
                        dec_imm  = XLEN'($signed(inst[31:20]));
                    end
                end
                5'b00000, 5'b11001: begin
                    dec_type = TY_I;
                    dec_imm  = XLEN'($signed(inst[31:20]));
                end
                5'b01000: begin
                    dec_type = TY_S;
                    dec_imm  = XLEN'($signed({inst[31:25], inst[11:7]}));
                end
                5'b11000: begin
                    dec_type = TY_B;
                    dec_imm  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                end
                5'b01101, 5'b00101: begin
                    dec_type = TY_U;
                    dec_imm  = XLEN'($signed({inst[31:12], 12'b0}));
                end
                5'b11011: begin
                    dec_type = TY_J;
                    dec_imm  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                end
                5'b01100: begin
                    dec_type = TY_R;
                end
                default: begin
                    dec_ill = 1'b1;
                end
            endcase
        end
    end

    // Occupancy transitions; a full buffer cannot see a push because in_ready is already low.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_TWO;
                else if (!push && pop) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Buffer state, head/skid payload and registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            rdy_q     <= 1'b0;
            head_imm  <= '0;
            head_type <= '0;
            head_ill  <= 1'b0;
            skid_imm  <= '0;
            skid_type <= '0;
            skid_ill  <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != ST_TWO);
            if ((state == ST_EMPTY && push) || (state == ST_ONE && push && pop)) begin
                head_imm  <= dec_imm;
                head_type <= dec_type;
                head_ill  <= dec_ill;
            end else if (state == ST_ONE && push) begin
                skid_imm  <= dec_imm;
                skid_type <= dec_type;
                skid_ill  <= dec_ill;
            end else if (state == ST_TWO && pop) begin
                head_imm  <= skid_imm;
                head_type <= skid_type;
                head_ill  <= skid_ill;
            end
        end
    end

    // Saturating count of accepted illegal words; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || ill_clr) begin
            ill_cnt <= '0;
        end else if (push && dec_ill && ill_cnt != {CNT_W{1'b1}}) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
Parameters:
REQ-001 SHALL have parameter XLEN, default 32, the output immediate width; legal values are 32 and 64 only.
REQ-002 SHALL have parameter CNT_W, default 16, the illegal-instruction counter width.

Ports:
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, in_inst is valid.
REQ-006 SHALL have port in_ready, output, 1, the block can accept an instruction (registered).
REQ-007 SHALL have port in_inst, input, 32, RV32 instruction word.
REQ-008 SHALL have port out_valid, output, 1, the head entry is valid.
REQ-009 SHALL have port out_ready, input, 1, the consumer accepts the head entry.
REQ-010 SHALL have port out_imm, output, XLEN, the extended immediate.
REQ-011 SHALL have port out_type, output, 3, the format code: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT.
REQ-012 SHALL have port out_illegal, output, 1, the instruction is unsupported.
REQ-013 SHALL have port ill_cnt, output, CNT_W, the saturating count of accepted illegal instructions.
REQ-014 SHALL have port ill_clr, input, 1, synchronous clear of ill_cnt.

Function
REQ-015 An input transfer SHALL occur iff in_valid && in_ready; an output transfer (pop) SHALL occur iff out_valid && out_ready.
REQ-016 Immediate decode SHALL key on in_inst[6:2]:
- 00100, 00000, 11001 -> I: sign-extend inst[31:20].
- 01000 -> S: sign-extend {inst[31:25], inst[11:7]}.
- 11000 -> B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- 01101, 00101 -> U: sign-extend {inst[31:12], 12'b0} to XLEN.
- 11011 -> J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- 01100 -> R: imm 0.
REQ-017 For opcode 00100 with inst[14:12] equal to 001 or 101, type SHALL be SHAMT and imm SHALL be zero-extended inst[20+SH-1:20], where SH=5 for XLEN=32 and SH=6 for XLEN=64.
REQ-018 If inst[1:0]!=2'b11 or the opcode is not listed in REQ-016, the entry SHALL carry illegal=1, type=0 and imm=0.
REQ-019 The datapath SHALL be a 2-entry elastic buffer (head register plus skid register) with states EMPTY, ONE and TWO; decode SHALL occur before the buffer, giving 1-cycle latency from input transfer to out_valid.
REQ-020 State transitions:
- EMPTY: push -> ONE.
- ONE: push without pop -> TWO; pop without push -> EMPTY; push and pop -> ONE, with the new entry in the head.
- TWO: pop -> ONE, with the skid entry moving to the head; no push is possible.
REQ-021 Ordering SHALL be strict FIFO; no entry SHALL be dropped or duplicated.
REQ-022 in_ready SHALL be registered and equal to (next_state != TWO); it SHALL be independent of out_ready in the same cycle.
REQ-023 out_imm, out_type and out_illegal SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 ill_cnt SHALL increment by 1 on each input transfer with illegal=1 and SHALL saturate at 2^CNT_W-1.
REQ-025 ill_clr SHALL have priority: ill_clr=1 SHALL set ill_cnt=0 even if an illegal push occurs in the same cycle.
REQ-026 When XLEN is not 32 or 64, elaboration SHALL fail.

Reset
REQ-027 With rst_n=0 at a clock edge, the block SHALL go to state EMPTY with:
- out_valid=0, out_imm=0, out_type=0, out_illegal=0;
- ill_cnt=0, in_ready=0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n returns high; reset mid-operation SHALL discard both buffered entries.

Verification
REQ-029 Stream 0xFFF00093 with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, type=1; a second instruction 0xFE000EE3 -> out_imm=0xFFFFFFFC, type=3.
REQ-030 Push 3 back-to-back instructions with out_ready=0 -> in_ready=0 after 2 accepts; raise out_ready -> the 3 entries emerge in order; in_ready returns to 1 one cycle after the first pop.
REQ-031 XLEN=64: 0x800000B7 -> out_imm=0xFFFFFFFF80000000, type=4; 0x03F09093 -> out_imm=63, type=6.
REQ-032 Push 0x00000000 -> illegal=1, imm=0, ill_cnt=1; with CNT_W=2, 5 illegal pushes -> ill_cnt=3; ill_clr together with an illegal push -> ill_cnt=0.
REQ-033 In state TWO, assert rst_n=0 for 1 cycle -> out_valid=0, ill_cnt=0, in_ready=0, then in_ready=1 the next cycle; no stale entry is emitted.
